uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` byte transmitter between `NUM_REQ` independent requesters. Each requester presents bytes on its own valid/ready port. The arbiter accepts one byte at a time into a single holding register and presents it to `uart_tx` on a valid/ready port. It sits between the firmware/logic byte sources and the UART transmitter, on the same clock domain.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rr_pick.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   UART_BYTE_W       : width of one UART byte
//   uart_arb_state_e  : arbiter FSM state encoding (S_ARB / S_SEND, 1 bit)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    S_ARB  = 1'b0,  // holding register empty, looking for a requester
    S_SEND = 1'b1   // holding register full, presenting byte to uart_tx
  } uart_arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational rotate-priority search. Returns the first set bit of valid_i,
// searching upward from ptr_i and wrapping at NUM_REQ-1.
// Ports:
//   valid_i  [NUM_REQ-1:0] : candidate request bits
//   ptr_i    [IDX_W-1:0]   : index with highest priority (must be < NUM_REQ)
//   found_o                : at least one candidate is set
//   index_o  [IDX_W-1:0]   : winning index (0 when nothing is found)
// -----------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   index_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the offsets from farthest to nearest so the nearest valid candidate
  // is the last one written and therefore wins, without needing a break.
  always_comb begin
    found_o  = 1'b0;
    index_o  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = cand[IDX_W-1:0];
      if (valid_i[cand_idx]) begin
        found_o = 1'b1;
        index_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ
// requesters. One byte at a time is accepted into a holding register and then
// presented to uart_tx over a valid/ready port.
//
// Optional feature macro: UART_ARB_PKT_LOCK_EN
//   defined   : packet lock -- after a byte with req_last=0 only the current
//               owner is considered until it sends a byte with req_last=1.
//   undefined : per-byte round-robin, req_last ignored.
//
// Ports:
//   clk        : system clock
//   resetn     : asynchronous active-low reset
//   req_data   : NUM_REQ bytes, requester i on [8*i+7:8*i]
//   req_valid  : per-requester byte valid
//   req_last   : per-requester end-of-packet flag (lock build only)
//   req_ready  : per-requester accept, combinational, at most one bit high
//   m_data     : held byte to uart_tx
//   m_valid    : byte valid to uart_tx
//   m_ready    : ready from uart_tx
//   grant_id   : index of the requester owning the held byte
//   busy       : holding register full
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [GNT_W-1:0]               grant_id,
  output logic                           busy
);

  uart_arb_state_e        state_q;
  logic [UART_BYTE_W-1:0] hold_q;
  logic [GNT_W-1:0]       grant_q;
  logic [GNT_W-1:0]       rr_ptr_q;
  logic [GNT_W-1:0]       rr_ptr_d;
  logic                   m_valid_q;
  logic                   busy_q;

  logic [NUM_REQ-1:0]     cand_valid;
  logic                   pick_found;
  logic [GNT_W-1:0]       pick_idx;
  logic [UART_BYTE_W-1:0] pick_data;
  logic                   accept;

`ifdef UART_ARB_PKT_LOCK_EN
  logic locked_q;
  logic pick_last;

  // While a packet is open only its owner may compete; the pointer search
  // then can only land on grant_q.
  always_comb begin
    cand_valid = req_valid;
    if (locked_q) begin
      cand_valid = req_valid & (NUM_REQ'(1) << grant_q);
    end
  end

  assign pick_last = req_last[pick_idx];
`else
  logic unused_last;

  assign cand_valid  = req_valid;
  assign unused_last = ^req_last;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GNT_W)
  ) u_pick (
    .valid_i (cand_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GNT_W'(i)) begin
        pick_data = req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  // Ready is gated by resetn so that every output shows its reset value
  // immediately when reset is asserted, not only after the next edge.
  always_comb begin
    req_ready = '0;
    if (resetn && (state_q == S_ARB) && pick_found) begin
      req_ready[pick_idx] = 1'b1;
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign rr_ptr_d = (pick_idx == GNT_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_ARB;
      hold_q    <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
      locked_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_ARB: begin
          if (accept) begin
            hold_q    <= pick_data;
            grant_q   <= pick_idx;
            rr_ptr_q  <= rr_ptr_d;
            m_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_SEND;
`ifdef UART_ARB_PKT_LOCK_EN
            locked_q  <= ~pick_last;
`endif
          end
        end
        S_SEND: begin
          // m_valid_q is always 1 here, so m_ready alone completes the handshake.
          if (m_ready) begin
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_ARB;
          end
        end
        default: begin
          state_q <= S_ARB;
        end
      endcase
    end
  end

  assign m_data   = hold_q;
  assign m_valid  = m_valid_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     m_data;
  logic           m_valid;
  logic           m_ready;
  logic [1:0]     grant_id;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester byte sources: {last, data}
  logic [8:0]  src_q [N][$];
  // Scoreboard: {grant index, data} in expected transmit order
  logic [15:0] exp_q [$];
  logic [N-1:0] acc;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
  endtask

  task automatic expect_b(input int r, input logic [7:0] d);
    exp_q.push_back({8'(r), d});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #3;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_mvalid(input string name, input int budget);
    int n;
    n = 0;
    while (!m_valid && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk(name, m_valid, 1);
  endtask

  // Requester driver: a byte leaves its source once seen accepted mid-cycle.
  initial begin
    logic [8:0] e;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          e = src_q[i][0];
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = e[7:0];
          req_last[i]        = e[8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor: pop and compare on every output handshake.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        chk("req_ready_onehot0", 32'($onehot0(req_ready)), 1);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got grant=%0d data=0x%0h, want none", grant_id, m_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_grant", 32'(grant_id), 32'(e[15:8]));
            chk("out_data", 32'(m_data), 32'(e[7:0]));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_in_reset", {req_ready, m_valid, m_data, grant_id, busy}, 0);
    resetn = 1'b1;
    @(posedge clk);
    #3;
    chk("rst_after_release", {req_ready, m_valid, m_data, grant_id, busy}, 0);

    // Single requester
    send(1, 8'hA5, 1'b1);
    expect_b(1, 8'hA5);
    @(posedge clk);
    #3;
    chk("single_ready", req_ready, 4'b0010);
    chk("single_busy_pre", busy, 0);
    @(posedge clk);
    #3;
    chk("single_mvalid", m_valid, 1);
    chk("single_data", m_data, 8'hA5);
    chk("single_grant", grant_id, 1);
    chk("single_busy", busy, 1);
    chk("single_ready_off", req_ready, 0);
    m_ready = 1'b1;
    @(posedge clk);
    #3;
    chk("single_busy_drop", {busy, m_valid}, 0);
    drain("single_drain", 20);

    // All four valid from reset
    resetn = 1'b0;
    for (int r = 0; r < N; r++) begin
      send(r, 8'(r), 1'b1);
      send(r, 8'(r), 1'b1);
    end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) expect_b(r, 8'(r));
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    drain("rr4_drain", 60);

    // Wrap-around: pointer is back at 0 after the grant to 3
    send(0, 8'h10, 1'b1);
    send(2, 8'h12, 1'b1);
    expect_b(0, 8'h10);
    expect_b(2, 8'h12);
    drain("wrap_drain", 30);

    // Backpressure: pointer is at 3
    m_ready = 1'b0;
    send(3, 8'hC3, 1'b1);
    send(1, 8'h3C, 1'b1);
    expect_b(3, 8'hC3);
    expect_b(1, 8'h3C);
    wait_mvalid("bp_first_valid", 10);
    chk("bp_first_grant", grant_id, 3);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #3;
      chk("bp_hold", {m_valid, m_data, grant_id, req_ready}, {1'b1, 8'hC3, 2'd3, 4'b0000});
    end
    m_ready = 1'b1;
    @(posedge clk);
    #3;
    chk("bp_next_ready", {m_valid, req_ready}, {1'b0, 4'b0010});
    @(posedge clk);
    #3;
    chk("bp_next_grant", {m_valid, grant_id, m_data}, {1'b1, 2'd1, 8'h3C});
    drain("bp_drain", 20);

    // Reset mid-send: pointer would favour 3, reset brings it back to 0
    m_ready = 1'b0;
    send(2, 8'h77, 1'b1);
    wait_mvalid("rstmid_valid", 10);
    chk("rstmid_grant", grant_id, 2);
    resetn = 1'b0;
    #1;
    chk("rstmid_async", {req_ready, m_valid, m_data, grant_id, busy}, 0);
    send(0, 8'h50, 1'b1);
    send(3, 8'h53, 1'b1);
    expect_b(0, 8'h50);
    expect_b(3, 8'h53);
    repeat (2) @(posedge clk);
    #3;
    resetn  = 1'b1;
    m_ready = 1'b1;
    drain("rstmid_drain", 30);

    // Packet lock: move pointer to 2, then req2 sends a 3-byte packet vs req0
    send(1, 8'h31, 1'b1);
    expect_b(1, 8'h31);
    drain("lock_prep_drain", 20);
    send(2, 8'h20, 1'b0);
    send(2, 8'h21, 1'b0);
    send(2, 8'h22, 1'b1);
    send(0, 8'h00, 1'b1);
    send(0, 8'h01, 1'b1);
    send(0, 8'h02, 1'b1);
`ifdef UART_ARB_PKT_LOCK_EN
    expect_b(2, 8'h20);
    expect_b(2, 8'h21);
    expect_b(2, 8'h22);
    expect_b(0, 8'h00);
    expect_b(0, 8'h01);
    expect_b(0, 8'h02);
`else
    expect_b(2, 8'h20);
    expect_b(0, 8'h00);
    expect_b(2, 8'h21);
    expect_b(0, 8'h01);
    expect_b(2, 8'h22);
    expect_b(0, 8'h02);
`endif
    drain("lock_drain", 60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
